// File: rtl/sync_fifo_reader.sv
// Read-side drain engine for a registered-output sync FIFO.
// Skid buffer absorbs read latency; m_ready never reaches fifo_r_en.
module sync_fifo_reader #(
  parameter int FIFO_data_size = 3,
  parameter int CNT_W          = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      fifo_empty,
  input  logic [FIFO_data_size-1:0] fifo_data,
  output logic                      fifo_r_en,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [FIFO_data_size-1:0] m_data,
  output logic                      busy,
  output logic [CNT_W-1:0]          words_out
);

  logic [FIFO_data_size-1:0] mem [3];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [1:0] occ;
  logic       inflight;
  logic       push;
  logic       pop;
  logic [2:0] fill;

  function automatic logic [1:0] nxt(
    input logic [1:0] p
  );
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Reserve a slot for the word still on the FIFO output.
  assign fill      = {1'b0, occ} + {2'b0, inflight};
  assign fifo_r_en = rst & en & ~fifo_empty
                   & (fill < 3'd3);

  assign push    = inflight;
  assign pop     = m_valid & m_ready;
  assign m_valid = (occ != 2'd0);
  assign m_data  = mem[rd_ptr];
  assign busy    = m_valid | inflight;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr    <= 2'd0;
      rd_ptr    <= 2'd0;
      occ       <= 2'd0;
      inflight  <= 1'b0;
      words_out <= '0;
    end else begin
      inflight <= fifo_r_en;
      if (push) wr_ptr <= nxt(wr_ptr);
      if (pop) begin
        rd_ptr    <= nxt(rd_ptr);
        words_out <= words_out + CNT_W'(1);
      end
      unique case ({push, pop})
        2'b10:   occ <= occ + 2'd1;
        2'b01:   occ <= occ - 2'd1;
        default: occ <= occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= fifo_data;
  end

endmodule

// File: tb/tb_sync_fifo_reader.sv
// Randomized scoreboard bench for sync_fifo_reader.
// Includes a behavioural FIFO with one-cycle registered read data.
module tb_sync_fifo_reader;

  localparam int DW = 3;
  localparam int CW = 3;

  logic          clk;
  logic          rst;
  logic          en;
  logic          fifo_empty;
  logic [DW-1:0] fifo_data;
  logic          fifo_r_en;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          busy;
  logic [CW-1:0] words_out;

  logic          wr;
  logic [DW-1:0] wdata;

  logic [DW-1:0] fifo_q [$];
  logic [DW-1:0] sb [$];

  int tests;
  int fails;

  int owned;
  bit infl_m;
  int cnt_m;

  sync_fifo_reader #(
    .FIFO_data_size(DW),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .fifo_empty(fifo_empty),
    .fifo_data(fifo_data),
    .fifo_r_en(fifo_r_en),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data(m_data),
    .busy(busy),
    .words_out(words_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string name,
    input int act,
    input int exp
  );
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // FIFO model: empty and data_out update on the consuming edge.
  always @(posedge clk) begin
    if (fifo_r_en && fifo_q.size() != 0)
      fifo_data <= fifo_q.pop_front();
    if (wr) fifo_q.push_back(wdata);
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Monitor: owned = words taken from FIFO but not yet delivered.
  always begin
    bit exp_ren;
    bit exp_valid;
    bit do_pop;
    @(negedge clk);
    #1;
    if (!rst) begin
      owned  = 0;
      infl_m = 0;
      cnt_m  = 0;
      chk("rst_m_valid", int'(m_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_r_en", int'(fifo_r_en), 0);
      chk("rst_words_out", int'(words_out), 0);
    end else begin
      exp_ren   = en && !fifo_empty && owned < 3;
      exp_valid = (owned - int'(infl_m)) != 0;
      chk("r_en", int'(fifo_r_en), int'(exp_ren));
      chk("m_valid", int'(m_valid), int'(exp_valid));
      chk("busy", int'(busy), int'(owned != 0));
      chk("words_out", int'(words_out), cnt_m % 8);
      do_pop = exp_valid && m_ready;
      if (exp_valid) begin
        if (sb.size() == 0) begin
          chk("sb_underflow", 1, 0);
        end else begin
          chk("m_data", int'(m_data), int'(sb[0]));
          if (do_pop) void'(sb.pop_front());
        end
      end
      owned  = owned + int'(exp_ren) - int'(do_pop);
      infl_m = exp_ren;
      if (do_pop) cnt_m++;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic put(input logic [DW-1:0] w);
    wr    = 1'b1;
    wdata = w;
    sb.push_back(w);
    @(negedge clk);
    wr = 1'b0;
  endtask

  // Words already read out of the FIFO are lost on reset.
  task automatic hit_reset(input int n);
    rst = 1'b0;
    wr  = 1'b0;
    sb  = fifo_q;
    idle(n);
    rst = 1'b1;
  endtask

  initial begin
    tests   = 0;
    fails   = 0;
    rst     = 1'b0;
    en      = 1'b1;
    m_ready = 1'b0;
    wr      = 1'b0;
    wdata   = '0;
    idle(3);
    rst = 1'b1;
    en  = 1'b0;

    put(3'b101);
    en      = 1'b1;
    m_ready = 1'b1;
    idle(6);

    en = 1'b0;
    for (int i = 0; i < 4; i++) put(DW'(i));
    en = 1'b1;
    idle(8);

    en      = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) put(DW'($urandom));
    en = 1'b1;
    idle(6);
    m_ready = 1'b1;
    idle(8);

    en = 1'b0;
    for (int i = 0; i < 4; i++) put(DW'($urandom));
    en = 1'b1;
    idle(2);
    en = 1'b0;
    idle(6);
    en = 1'b1;
    idle(8);

    en      = 1'b0;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) put(DW'($urandom));
    en = 1'b1;
    idle(3);
    hit_reset(2);
    m_ready = 1'b1;
    idle(10);

    for (int c = 0; c < 800; c++) begin
      en      = ($urandom_range(0, 7) != 0);
      m_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) begin
        hit_reset(1);
      end else begin
        if (fifo_q.size() < 8 && $urandom_range(0, 2) != 0) begin
          wr    = 1'b1;
          wdata = DW'($urandom);
          sb.push_back(wdata);
        end else begin
          wr = 1'b0;
        end
        @(negedge clk);
      end
    end

    wr      = 1'b0;
    en      = 1'b1;
    m_ready = 1'b1;
    idle(30);
    chk("drain_sb_empty", sb.size(), 0);
    chk("drain_fifo_empty", fifo_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
